// File: rtl/demux16_collector_pkg.sv
// rtl/demux16_collector_pkg.sv - shared state encoding and default sizes for the bit collector
package demux16_collector_pkg;

    // Collector states: FILL gathers bits, HOLD presents the finished word
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } fsmStateT;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 4;

endpackage

// File: rtl/demux16_collector_dec4to16.sv
// rtl/demux16_collector_dec4to16.sv - enable-gated select to one-hot write-enable decoder
module dec4to16 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] oneHot
);

    // One write-enable per bit position, all low unless a bit is being accepted
    always_comb begin
        oneHot = '0;
        if (enable) begin
            oneHot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux16_collector.sv
// rtl/demux16_collector.sv - serial bit collector assembling indexed bits into a parallel word
module demux16_collector
    import demux16_collector_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SEL_W      = DEF_SEL_W,
    parameter bit SEQUENTIAL = 1'b0
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         DataIn,
    input  logic                         DataValid,
    output logic                         DataReady,
    input  logic [SEL_W-1:0]             Select,
    input  logic                         Flush,
    output logic [WIDTH-1:0]             DataOut,
    output logic                         WordValid,
    input  logic                         WordReady,
    output logic                         Overwrite,
    output logic [$clog2(WIDTH+1)-1:0]   FillCount
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    fsmStateT         state;
    logic [WIDTH-1:0] mask;
    logic [SEL_W-1:0] seqIdx;
    logic [SEL_W-1:0] seqIdxNext;
    logic [SEL_W-1:0] wrIdx;
    logic             readyReg;
    logic             accept;
    logic [WIDTH-1:0] wrEn;
    logic [WIDTH-1:0] maskNext;
    logic [CNT_W-1:0] fillSum;

    // A bit is taken only in FILL and never on a flush cycle, so a flushed bit is simply dropped
    assign accept     = DataValid & readyReg & ~Flush & (state == ST_FILL);
    assign wrIdx      = SEQUENTIAL ? seqIdx : Select;
    assign seqIdxNext = (seqIdx == SEL_W'(WIDTH - 1)) ? '0 : seqIdx + 1'b1;
    assign maskNext   = mask | wrEn;

    dec4to16 #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_dec (
        .enable (accept),
        .sel    (wrIdx),
        .oneHot (wrEn)
    );

    // Number of distinct positions written so far
    always_comb begin
        fillSum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fillSum = fillSum + {{(CNT_W-1){1'b0}}, mask[i]};
        end
    end

    assign FillCount = fillSum;
    assign DataReady = readyReg;

    // Collector state machine with its word, mask, index counter and registered handshake outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= ST_FILL;
            DataOut   <= '0;
            mask      <= '0;
            seqIdx    <= '0;
            WordValid <= 1'b0;
            readyReg  <= 1'b1;
            Overwrite <= 1'b0;
        end else begin
            Overwrite <= 1'b0;
            if (Flush) begin
                mask      <= '0;
                seqIdx    <= '0;
                state     <= ST_FILL;
                WordValid <= 1'b0;
                readyReg  <= 1'b1;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (accept) begin
                            DataOut   <= (DataOut & ~wrEn) | (wrEn & {WIDTH{DataIn}});
                            mask      <= maskNext;
                            Overwrite <= |(mask & wrEn);
                            if (SEQUENTIAL) begin
                                seqIdx <= seqIdxNext;
                            end
                            if (&maskNext) begin
                                state     <= ST_HOLD;
                                WordValid <= 1'b1;
                                readyReg  <= 1'b0;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (WordReady) begin
                            mask      <= '0;
                            seqIdx    <= '0;
                            state     <= ST_FILL;
                            WordValid <= 1'b0;
                            readyReg  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_FILL;
                    end
                endcase
            end
        end
    end

endmodule
